// File: rtl/fpu16_pkg.sv
// Shared types and constants for the 16-bit FPU operand front end.
// FRAME_CHECKSUM_EN selects the six-byte frame with a trailing XOR checksum.
package fpu16_pkg;

    typedef enum logic [2:0] {
        S_OP,
        S_AH,
        S_AL,
        S_BH,
        S_BL,
        S_CHK
    } state_e;

    localparam int DATA_LSB = 0;
    localparam int STB_BIT  = 8;
    localparam int SYNC_BIT = 9;
    localparam int PIN_W    = 10;
    localparam int BYTE_W   = 8;
    localparam int OP_W     = 4;

`ifdef FRAME_CHECKSUM_EN
    localparam int FRAME_LEN = 6;
`else
    localparam int FRAME_LEN = 5;
`endif

endpackage

// File: rtl/operand_deserializer_pin_sync.sv
// Pin-bus synchronizer with strobe rising-edge detect gated by an arm flag.
// Bytes are only recognised after the strobe has been seen low since reset.
module pin_sync
    import fpu16_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [PIN_W-1:0]  pins,
    output logic [BYTE_W-1:0] byte_o,
    output logic              abort_o,
    output logic              rise_o
);

    logic [SYNC_STAGES-1:0][PIN_W-1:0] sync_q, sync_d;
    logic [SYNC_STAGES-1:0]            fill_q, fill_d;
    logic                              prev_q, prev_d;
    logic                              armed_q, armed_d;
    logic                              stb;
    logic                              valid;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], pins};
        // fill tracks how far real pin data has travelled since reset, so the
        // reset zeros in the chain cannot masquerade as a low strobe
        fill_d  = {fill_q[SYNC_STAGES-2:0], 1'b1};
        stb     = sync_q[SYNC_STAGES-1][STB_BIT];
        valid   = fill_q[SYNC_STAGES-1];
        prev_d  = stb;
        armed_d = armed_q | (valid & ~stb);
        rise_o  = valid & armed_q & stb & ~prev_q;
        byte_o  = sync_q[SYNC_STAGES-1][DATA_LSB +: BYTE_W];
        abort_o = sync_q[SYNC_STAGES-1][SYNC_BIT];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q  <= '0;
            fill_q  <= '0;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            fill_q  <= fill_d;
            prev_q  <= prev_d;
            armed_q <= armed_d;
        end
    end

endmodule

// File: rtl/operand_deserializer.sv
// Byte-serial operand frame collector: OP, A_HI, A_LO, B_HI, B_LO (+CHK when
// FRAME_CHECKSUM_EN), committed atomically to num1/num2/op with a start pulse.
module operand_deserializer
    import fpu16_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int WIDTH       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [PIN_W-1:0] in,
    output logic [WIDTH-1:0] num1,
    output logic [WIDTH-1:0] num2,
    output logic [OP_W-1:0]  op,
    output logic             start,
    output logic             err
);

    logic [BYTE_W-1:0] rx_byte;
    logic              rx_abort;
    logic              rx_rise;

    pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_pin_sync (
        .clock   (clock),
        .reset   (reset),
        .pins    (in),
        .byte_o  (rx_byte),
        .abort_o (rx_abort),
        .rise_o  (rx_rise)
    );

    state_e            state_q, state_d;
    logic [OP_W-1:0]   op_sh_q, op_sh_d;
    logic [WIDTH-1:0]  a_sh_q, a_sh_d;
    logic [WIDTH-1:0]  b_sh_q, b_sh_d;
    logic [WIDTH-1:0]  num1_q, num1_d;
    logic [WIDTH-1:0]  num2_q, num2_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic              start_q, start_d;
    logic              commit;
`ifdef FRAME_CHECKSUM_EN
    logic [BYTE_W-1:0] chk_q, chk_d;
    logic              err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        op_sh_d = op_sh_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        num1_d  = num1_q;
        num2_d  = num2_q;
        op_d    = op_q;
        start_d = 1'b0;
        commit  = 1'b0;
`ifdef FRAME_CHECKSUM_EN
        chk_d   = chk_q;
        err_d   = 1'b0;
`endif
        // abort wins over a byte arriving in the same cycle
        if (rx_abort) begin
            state_d = S_OP;
            op_sh_d = '0;
            a_sh_d  = '0;
            b_sh_d  = '0;
`ifdef FRAME_CHECKSUM_EN
            chk_d   = '0;
`endif
        end else if (rx_rise) begin
`ifdef FRAME_CHECKSUM_EN
            chk_d = chk_q ^ rx_byte;
`endif
            unique case (state_q)
                S_OP: begin
                    op_sh_d = rx_byte[OP_W-1:0];
`ifdef FRAME_CHECKSUM_EN
                    chk_d   = rx_byte;
`endif
                    state_d = S_AH;
                end
                S_AH: begin
                    a_sh_d[WIDTH-1 -: BYTE_W] = rx_byte;
                    state_d = S_AL;
                end
                S_AL: begin
                    a_sh_d[BYTE_W-1:0] = rx_byte;
                    state_d = S_BH;
                end
                S_BH: begin
                    b_sh_d[WIDTH-1 -: BYTE_W] = rx_byte;
                    state_d = S_BL;
                end
                S_BL: begin
                    b_sh_d[BYTE_W-1:0] = rx_byte;
`ifdef FRAME_CHECKSUM_EN
                    state_d = S_CHK;
`else
                    commit  = 1'b1;
                    state_d = S_OP;
`endif
                end
`ifdef FRAME_CHECKSUM_EN
                S_CHK: begin
                    state_d = S_OP;
                    if (rx_byte == chk_q) commit = 1'b1;
                    else                  err_d  = 1'b1;
                end
`endif
                default: state_d = S_OP;
            endcase
        end

        if (commit) begin
            num1_d  = a_sh_d;
            num2_d  = b_sh_d;
            op_d    = op_sh_d;
            start_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_OP;
            op_sh_q <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            num1_q  <= '0;
            num2_q  <= '0;
            op_q    <= '0;
            start_q <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
            chk_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            op_sh_q <= op_sh_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            num1_q  <= num1_d;
            num2_q  <= num2_d;
            op_q    <= op_d;
            start_q <= start_d;
`ifdef FRAME_CHECKSUM_EN
            chk_q   <= chk_d;
            err_q   <= err_d;
`endif
        end
    end

    assign num1  = num1_q;
    assign num2  = num2_q;
    assign op    = op_q;
    assign start = start_q;
`ifdef FRAME_CHECKSUM_EN
    assign err   = err_q;
`else
    assign err   = 1'b0;
`endif

endmodule

// File: tb/tb_operand_deserializer.sv
// Bench for operand_deserializer: directed frames plus randomized frames and
// aborts, checked against a frame-level byte-list model.
module tb_operand_deserializer;
    import fpu16_pkg::*;

    localparam int SYNC_STAGES = 2;
    localparam int LAT_K       = SYNC_STAGES + 1;  // negedge index where a commit is visible

    logic        clock = 1'b0;
    logic        reset;
    logic [9:0]  pins;
    logic [15:0] num1, num2;
    logic [3:0]  op;
    logic        start, err;

    operand_deserializer #(.SYNC_STAGES(SYNC_STAGES), .WIDTH(16)) dut (
        .clock (clock),
        .reset (reset),
        .in    (pins),
        .num1  (num1),
        .num2  (num2),
        .op    (op),
        .start (start),
        .err   (err)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // scoreboard: committed value as {num1, num2, op}
    logic [35:0] exp_q[$];
    logic [35:0] cur_exp;
    logic [7:0]  fbuf[6];
    int          fidx;

    task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_byte(input logic [7:0] b, output bit commit, output bit bad);
        bit ok;
        commit = 1'b0;
        bad    = 1'b0;
        fbuf[fidx] = b;
        fidx++;
        if (fidx == FRAME_LEN) begin
            fidx = 0;
            ok = 1'b1;
`ifdef FRAME_CHECKSUM_EN
            ok = ((fbuf[0] ^ fbuf[1] ^ fbuf[2] ^ fbuf[3] ^ fbuf[4]) == fbuf[5]);
`endif
            if (ok) begin
                commit = 1'b1;
                exp_q.push_back({fbuf[1], fbuf[2], fbuf[3], fbuf[4], fbuf[0][3:0]});
            end else begin
                bad = 1'b1;
            end
        end
    endtask

    // Called right after a negedge; checks outputs on each following negedge.
    task automatic watch(input string tag, input int k, input bit commit, input bit bad);
        @(negedge clock);
        if (commit && k == LAT_K && exp_q.size() > 0) cur_exp = exp_q.pop_front();
        check({tag, "_start"}, {35'd0, start}, {35'd0, commit && k == LAT_K});
        check({tag, "_err"}, {35'd0, err}, {35'd0, bad && k == LAT_K});
        check({tag, "_outs"}, {num1, num2, op}, cur_exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input string tag);
        bit c, bad;
        int hi, lo;
        hi = $urandom_range(3, 5);
        lo = $urandom_range(2, 4);
        model_byte(b, c, bad);
        pins = {1'b0, 1'b1, b};
        for (int k = 1; k <= hi + lo; k++) begin
            watch(tag, k, c, bad);
            if (k == hi) pins[8] = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] o, input logic [7:0] ah, input logic [7:0] al,
                              input logic [7:0] bh, input logic [7:0] bl, input string tag);
        send_byte(o, tag);
        send_byte(ah, tag);
        send_byte(al, tag);
        send_byte(bh, tag);
        send_byte(bl, tag);
`ifdef FRAME_CHECKSUM_EN
        send_byte(o ^ ah ^ al ^ bh ^ bl, tag);
`endif
    endtask

    // with_stb raises the strobe together with the abort pin
    task automatic abort_frame(input bit with_stb, input logic [7:0] b, input string tag);
        fidx = 0;
        pins = {1'b1, with_stb, b};
        for (int k = 1; k <= 3; k++) watch(tag, k, 1'b0, 1'b0);
        pins = '0;
        for (int k = 1; k <= 4; k++) watch(tag, k, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input bit hold_stb, input string tag);
        pins  = hold_stb ? {2'b01, 8'h05} : 10'd0;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        fidx = 0;
        exp_q.delete();
        cur_exp = '0;
        check({tag, "_rst_outs"}, {num1, num2, op}, 36'd0);
        check({tag, "_rst_start"}, {35'd0, start}, 36'd0);
        check({tag, "_rst_err"}, {35'd0, err}, 36'd0);
        reset = 1'b0;
        for (int k = 1; k <= 6; k++) watch(tag, k, 1'b0, 1'b0);
        pins = '0;
        for (int k = 1; k <= 3; k++) watch(tag, k, 1'b0, 1'b0);
    endtask

    initial begin
        reset   = 1'b1;
        pins    = '0;
        fidx    = 0;
        cur_exp = '0;

        do_reset(1'b0, "init");

        send_frame(8'h01, 8'h3C, 8'h00, 8'h40, 8'h00, "basic");
        check("basic_const", {num1, num2, op}, {16'h3C00, 16'h4000, 4'h1});

        send_byte(8'h02, "partial");
        send_byte(8'h12, "partial");
        abort_frame(1'b0, 8'h00, "abort");
        check("abort_hold", {num1, num2, op}, {16'h3C00, 16'h4000, 4'h1});
        send_frame(8'h03, 8'hC0, 8'h00, 8'h3C, 8'h00, "after_abort");
        check("after_abort_const", {num1, num2, op}, {16'hC000, 16'h3C00, 4'h3});

        do_reset(1'b1, "stb_held");
        send_frame(8'h07, 8'h12, 8'h34, 8'h56, 8'h78, "post_held");
        check("post_held_const", {num1, num2, op}, {16'h1234, 16'h5678, 4'h7});

        send_byte(8'h04, "pre_dual");
        send_byte(8'h11, "pre_dual");
        abort_frame(1'b1, 8'h55, "dual");
        send_frame(8'h0A, 8'hAB, 8'hCD, 8'hEF, 8'h01, "post_dual");
        check("post_dual_const", {num1, num2, op}, {16'hABCD, 16'hEF01, 4'hA});

        send_frame(8'hF5, 8'h11, 8'h22, 8'h33, 8'h44, "b2b_1");
        check("b2b_1_const", {num1, num2, op}, {16'h1122, 16'h3344, 4'h5});
        send_frame(8'h0C, 8'h99, 8'h88, 8'h77, 8'h66, "b2b_2");
        check("b2b_2_const", {num1, num2, op}, {16'h9988, 16'h7766, 4'hC});

        send_byte(8'h09, "mid_rst");
        send_byte(8'h42, "mid_rst");
        do_reset(1'b0, "mid_rst");
        send_frame(8'h02, 8'h00, 8'h01, 8'h80, 8'h00, "post_rst");
        check("post_rst_const", {num1, num2, op}, {16'h0001, 16'h8000, 4'h2});

`ifdef FRAME_CHECKSUM_EN
        send_byte(8'h01, "chk_ok"); send_byte(8'h3C, "chk_ok"); send_byte(8'h00, "chk_ok");
        send_byte(8'h40, "chk_ok"); send_byte(8'h00, "chk_ok"); send_byte(8'h7D, "chk_ok");
        check("chk_ok_const", {num1, num2, op}, {16'h3C00, 16'h4000, 4'h1});
        send_byte(8'h03, "chk_bad"); send_byte(8'h3C, "chk_bad"); send_byte(8'h00, "chk_bad");
        send_byte(8'h40, "chk_bad"); send_byte(8'h00, "chk_bad"); send_byte(8'h7C, "chk_bad");
        check("chk_bad_const", {num1, num2, op}, {16'h3C00, 16'h4000, 4'h1});
`endif

        for (int i = 0; i < 30; i++) begin
            logic [7:0] fb[6];
            int n;
            for (int j = 0; j < 5; j++) fb[j] = 8'($urandom_range(0, 255));
            fb[5] = fb[0] ^ fb[1] ^ fb[2] ^ fb[3] ^ fb[4];
            if ($urandom_range(0, 3) == 0) fb[5] = fb[5] ^ 8'($urandom_range(1, 255));
            if ($urandom_range(0, 5) == 0) begin
                n = $urandom_range(0, FRAME_LEN - 1);
                for (int j = 0; j < n; j++) send_byte(fb[j], "rnd_part");
                abort_frame(1'($urandom_range(0, 1)), fb[n], "rnd_abort");
            end else begin
                for (int j = 0; j < FRAME_LEN; j++) send_byte(fb[j], "rnd");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
